uart_frame_tx_ctrl: RTL and testbench

Sequences transmission of the 32-bit status word (`{board_ID, points}`) to the peer board over UART. It slices the word into a 5-byte frame: header byte, then the 4 word bytes MSB first. It pushes the bytes into the UART TX FIFO under `tx_full` back-pressure. It sits between the word-packing logic and the UART TX FIFO write port, and decides when a frame is sent: immediately on word change, and periodically as a keep-alive.

---
 rtl/uart_frame_tx_ctrl.sv | 106 ++++++++++
 tb/tb_uart_frame_tx_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_tx_ctrl.sv
// Slices the 32-bit status word into a 5-byte frame (header + 4 bytes, MSB first) for the UART TX FIFO.
// Latency: first byte one cycle after start; an unstalled frame takes 5 write cycles plus 1 DONE cycle. Backpressure: tx_full stalls the current byte in place.
// Frames start on a change of a nonzero word, or as a keep-alive once the resend timer expires.
module uart_frame_tx_ctrl #(
    parameter int         PERIOD_CYCLES = 1_000_000,
    parameter logic [7:0] HEADER        = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] tx_data_stack,
    input  logic        tx_full,
    output logic        wr_uart,
    output logic [7:0]  w_data,
    output logic        busy,
    output logic [15:0] frames_sent
);

    localparam int              TW           = $clog2(PERIOD_CYCLES);
    localparam logic [TW-1:0]   TIMER_RELOAD = TW'(PERIOD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   shadow_q, shadow_d;
    logic [31:0]   last_sent_q, last_sent_d;
    logic [2:0]    idx_q, idx_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [15:0]   frames_q, frames_d;
    logic          busy_q, busy_d;

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        last_sent_d = last_sent_q;
        idx_d       = idx_q;
        frames_d    = frames_q;
        timer_d     = (timer_q != '0) ? timer_q - TW'(1) : '0;
        wr_uart     = 1'b0;
        w_data      = 8'h00;

        case (state_q)
            IDLE: begin
                // Keep-alive only fires for a nonzero word; zero means no board ID yet.
                if (tx_data_stack != 32'd0 &&
                    (tx_data_stack != last_sent_q || timer_q == '0)) begin
                    shadow_d = tx_data_stack;
                    idx_d    = 3'd0;
                    timer_d  = TIMER_RELOAD;
                    state_d  = SEND;
                end
            end
            SEND: begin
                wr_uart = ~tx_full;
                case (idx_q)
                    3'd0:    w_data = HEADER;
                    3'd1:    w_data = shadow_q[31:24];
                    3'd2:    w_data = shadow_q[23:16];
                    3'd3:    w_data = shadow_q[15:8];
                    default: w_data = shadow_q[7:0];
                endcase
                if (!tx_full) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd4) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                last_sent_d = shadow_q;
                frames_d    = frames_q + 16'd1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == SEND) || (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            shadow_q    <= 32'd0;
            last_sent_q <= 32'd0;
            idx_q       <= 3'd0;
            timer_q     <= TIMER_RELOAD;
            frames_q    <= 16'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            last_sent_q <= last_sent_d;
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            frames_q    <= frames_d;
            busy_q      <= busy_d;
        end
    end

    assign busy        = busy_q;
    assign frames_sent = frames_q;

endmodule

// File: tb/tb_uart_frame_tx_ctrl.sv
// Randomized bench for uart_frame_tx_ctrl: a frame-level reference model predicts each FIFO write and a monitor checks them.
module tb_uart_frame_tx_ctrl;

    localparam int P = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] word = 32'd0;
    logic        tx_full = 1'b0;
    logic        wr_uart;
    logic [7:0]  w_data;
    logic        busy;
    logic [15:0] frames_sent;

    uart_frame_tx_ctrl #(.PERIOD_CYCLES(P), .HEADER(8'hA5)) dut (
        .clk           (clk),
        .rst           (rst),
        .tx_data_stack (word),
        .tx_full       (tx_full),
        .wr_uart       (wr_uart),
        .w_data        (w_data),
        .busy          (busy),
        .frames_sent   (frames_sent)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [7:0] b;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   nwrites = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h cycle=%0d", nm, act, req, cyc);
        end
    endtask

    // Reference model: a frame is a list of 5 bytes drained one per non-full cycle,
    // followed by one closing cycle. A keep-alive is due P edges after the last start.
    initial begin : model
        logic [7:0]  frame[$];
        bit          m_done;
        logic [31:0] m_last;
        logic [31:0] m_shadow;
        int          m_start;
        int          m_frames;
        m_done = 0; m_last = 0; m_shadow = 0; m_start = 0; m_frames = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                frame.delete();
                m_done   = 0;
                m_last   = 32'd0;
                m_frames = 0;
                m_start  = cyc + 1;
                chk("rst_wr_uart", {31'd0, wr_uart}, 32'd0);
                chk("rst_w_data", {24'd0, w_data}, 32'd0);
                chk("rst_busy", {31'd0, busy}, 32'd0);
                chk("rst_frames", {16'd0, frames_sent}, 32'd0);
            end else begin
                chk("busy", {31'd0, busy}, (frame.size() > 0 || m_done) ? 32'd1 : 32'd0);
                chk("frames_sent", {16'd0, frames_sent}, {16'd0, 16'(m_frames)});
                if (frame.size() > 0) begin
                    if (!tx_full) begin
                        exp_t e;
                        e.c = cyc;
                        e.b = frame.pop_front();
                        exp_q.push_back(e);
                        if (frame.size() == 0) m_done = 1;
                    end
                end else if (m_done) begin
                    m_done = 0;
                    m_last = m_shadow;
                    m_frames++;
                end else if (word != 32'd0 && (word != m_last || (cyc + 1) - m_start >= P)) begin
                    m_start  = cyc + 1;
                    m_shadow = word;
                    frame    = '{8'hA5, word[31:24], word[23:16], word[15:8], word[7:0]};
                end
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            #1;
            if (rst && wr_uart) begin
                nwrites++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: actual byte=%h at cycle %0d, required no write", w_data, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("write_cycle", cyc, e.c);
                    chk("w_data", {24'd0, w_data}, {24'd0, e.b});
                end
            end else if (rst && !busy) begin
                chk("w_data_idle", {24'd0, w_data}, 32'd0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_writes(input int n, input int budget);
        int target;
        int k;
        target = nwrites + n;
        k = 0;
        while (nwrites < target && k < budget) begin
            @(negedge clk);
            #2;
            k++;
        end
        chk("wait_writes_in_budget", (nwrites >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin : stim
        int r;
        tick(3);
        rst = 1'b1;

        // Zero word: nothing may be sent, not even keep-alives.
        tick(100);
        chk("no_tx_zero_word", nwrites, 32'd0);

        // First frame then periodic keep-alives of the same word.
        word = 32'h0300012C;
        tick(40);

        // Word change while a frame is in flight.
        word = 32'h11223344;
        wait_writes(2, 30);
        word = 32'h03000200;
        tick(25);

        // Random words and FIFO backpressure.
        for (int i = 0; i < 600; i++) begin
            tx_full = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 15);
            case (r)
                0:       word = 32'd0;
                1:       word = 32'h0300012C;
                2:       word = 32'h03000200;
                3:       word = $urandom;
                default: ;
            endcase
            tick(1);
        end
        tx_full = 1'b0;
        word = 32'h0300012C;
        tick(25);

        // Reset after the second byte of a frame, then restart with the same word.
        word = 32'hCAFE0001;
        wait_writes(2, 40);
        rst = 1'b0;
        #1;
        chk("async_rst_wr_uart", {31'd0, wr_uart}, 32'd0);
        chk("async_rst_w_data", {24'd0, w_data}, 32'd0);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        tick(30);

        chk("expected_queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
